uart_core: RTL
==============

# uart_core

Parametrised UART transceiver that replaces the bare uart_rx/uart_tx pair under the terminal top level. It adds configurable frame format (data bits, stop bits, optional parity), TX and RX FIFOs with valid/ready handshakes, and error detection. termbuffer connects to the FIFO side, and the FPGA pins connect to the serial side.

## Interface
- CLKS_PER_BIT, default 104, clocks per serial bit (12 MHz / 115200); must be ≥ 4.
- DATA_BITS, default 8, data bits per frame, range 5..8.
- STOP_BITS, default 1, stop bits per frame, 1 or 2.
- FIFO_DEPTH, default 16, entries per FIFO; power of two, ≥ 2.
- PARITY_ODD, default 0, 0 = even parity, 1 = odd; ignored unless parity compiled in.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- tx_data  in  DATA_BITS  word to transmit.
- tx_valid  in  1  tx_data valid.
- tx_ready  out  1  TX FIFO not full.
- rx_data  out  DATA_BITS  oldest received word (show-ahead).
- rx_valid  out  1  RX FIFO not empty.
- rx_ready  in  1  consumer pops rx_data.
- tx_serial  out  1  serial line out, idle high.
- rx_serial  in  1  serial line in, asynchronous.
- tx_active  out  1  TX FSM not IDLE.
- rx_frame_err  out  1  one-cycle pulse: stop bit sampled low.
- rx_parity_err  out  1  one-cycle pulse: parity mismatch (constant 0 without parity).
- rx_overrun  out  1  one-cycle pulse: word completed while RX FIFO full.
- tx_level, rx_level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.

## Operation
- **Reset values:** tx_serial=1, tx_active=0, tx_ready=1, rx_valid=0, all error pulses 0, both levels 0. Reset flushes both FIFOs.
- **Reset mid-frame:** reset aborts the frame in progress, and tx_serial goes high asynchronously.
- **TX push:** occurs on tx_valid & tx_ready.
- **TX FSM states:** IDLE → START → DATA → [PARITY] → STOP → IDLE.
  - In IDLE with a non-empty TX FIFO, the FSM pops one word and enters START.
  - Data is sent LSB first.
  - STOP lasts STOP_BITS × CLKS_PER_BIT cycles.
  - At the end of STOP, if the FIFO is non-empty, the FSM pops the next word and enters START directly, with no idle gap.
- **RX synchronisation:** rx_serial passes through a 2-flop synchroniser.
- **RX FSM states:** IDLE → START → DATA → [PARITY] → STOP → IDLE.
  - A falling edge in IDLE enters START.
  - The FSM samples at CLKS_PER_BIT/2 into START, then every CLKS_PER_BIT thereafter.
  - If START samples high, the edge was a glitch: return to IDLE with no pulse.
  - Only the first stop bit is checked.
- **RX completion** (evaluated at the stop-bit sample, in priority order):
  - Stop bit low → rx_frame_err pulse, word discarded.
  - Otherwise parity mismatch → rx_parity_err pulse, word discarded.
  - Otherwise FIFO full → rx_overrun pulse, word dropped; stored data is untouched.
  - Otherwise the word is pushed.
- **Simultaneous push and pop:** if an RX push and an rx_ready pop happen in the same cycle, both succeed, including when the FIFO is full (level unchanged). The TX side follows the same rule.
- **Levels:** count with wrap-free arithmetic. Pointers are $clog2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH.

## Timing
- **TX latency:** with TX idle and FIFO empty, tx_serial falls 2 cycles after the tx_valid&tx_ready edge. tx_active rises in the same cycle.
- **TX bit width:** each bit is held exactly CLKS_PER_BIT cycles.
- **TX frame length:** 1 + DATA_BITS + P + STOP_BITS bit periods, where P = 1 with parity, 0 without.
- **RX latency:** rx_valid rises 1 cycle after the stop-bit sample.
- **Error pulses:** issued in the cycle following the stop-bit sample.
- **Ready signals:** tx_ready reflects the registered level; there is no combinational path from tx_valid.

## Configuration
- Macro: UART_PARITY_EN.
- **Defined:** a PARITY state is inserted in both FSMs. TX sends the XOR of the data bits, inverted when PARITY_ODD=1. RX checks parity and drives rx_parity_err.
- **Undefined:** no PARITY state, no parity logic, rx_parity_err tied to 0, PARITY_ODD unused.

## Structure
- Package uart_pkg holds:
  - the TX/RX state enum (IDLE, START, DATA, PARITY, STOP);
  - a parity function;
  - the bit-counter width constant.
- Sub-module sync_fifo (WIDTH, DEPTH; push/pop/full/empty/level, show-ahead output) is instantiated twice.
- TX and RX FSMs live in uart_core.

## Test plan
All scenarios use CLKS_PER_BIT=4.
1. Push 0x55, default format → tx_serial reads 0,1,0,1,0,1,0,1,0,1, each bit 4 cycles, then idle high; tx_active high for 40 cycles.
2. Loop tx_serial to rx_serial, push 0xA5, 0x3C, 0xFF back-to-back → frames sent with no gap; rx pops 0xA5, 0x3C, 0xFF; no error pulses.
3. rx_ready=0, inject 17 frames (FIFO_DEPTH=16) → rx_level=16, exactly one rx_overrun, popped data equals the first 16 words.
4. Inject frame 0x12 with stop bit 0 → one rx_frame_err pulse; rx_level stays 0.
5. With UART_PARITY_EN, PARITY_ODD=0, inject 0x07 with parity bit 0 → rx_parity_err pulse, word discarded. Same frame with parity bit 1 → 0x07 received.
6. Assert rst mid-way through a TX data bit with 3 words queued → tx_serial=1 immediately, both levels 0, tx_ready=1 after release, no further frames sent.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state type, bit-counter width and parity helper for uart_core.
// Parity support in uart_core is compiled in with the UART_PARITY_EN macro.
package uart_pkg;

  // Common state set for both the TX and RX frame FSMs
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;

  // Largest supported data width and the counter wide enough to index it
  localparam int unsigned MAX_DATA_BITS = 8;
  localparam int unsigned BIT_CNT_W     = 3;

  // Parity bit to send/expect: XOR of the low nbits of data, inverted for odd parity
  function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data,
                                      input int unsigned               nbits,
                                      input logic                      odd);
    logic p;
    p = odd;
    for (int unsigned i = 0; i < MAX_DATA_BITS; i++) begin
      if (i < nbits) p = p ^ data[i];
    end
    return p;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// sync_fifo: single-clock show-ahead FIFO with occupancy count.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  // Storage array; contents need no reset because level gates visibility
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally modulo DEPTH; level tracks occupancy exactly
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_core.sv
// uart_core: UART transceiver with TX/RX FIFOs, configurable frame format and
// frame/parity/overrun error pulses. Define UART_PARITY_EN to add a parity bit.
module uart_core
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 104,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          tx_serial,
  input  logic                          rx_serial,
  output logic                          tx_active,
  output logic                          rx_frame_err,
  output logic                          rx_parity_err,
  output logic                          rx_overrun,
  output logic [$clog2(FIFO_DEPTH):0]   tx_level,
  output logic [$clog2(FIFO_DEPTH):0]   rx_level
);

  localparam int unsigned CNT_W = $clog2(STOP_BITS * CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0]     BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]     HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0]     STOP_END = CNT_W'(STOP_BITS * CLKS_PER_BIT - 1);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_BITS - 1);

  if (CLKS_PER_BIT < 4 || DATA_BITS < 5 || DATA_BITS > MAX_DATA_BITS ||
      STOP_BITS < 1 || STOP_BITS > 2 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || PARITY_ODD > 1) begin : g_bad_params
    $error("uart_core: unsupported parameter combination");
  end

  // ---------------------------------------------------------------- TX side
  uart_state_t          tx_state;
  logic [CNT_W-1:0]     tx_cnt;
  logic [BIT_CNT_W-1:0] tx_bit;
  logic [DATA_BITS-1:0] tx_shift;
  logic [DATA_BITS-1:0] tx_fifo_dout;
  logic                 tx_fifo_full;
  logic                 tx_fifo_empty;
  logic                 tx_pop;
  logic                 tx_line;
`ifdef UART_PARITY_EN
  logic                 tx_par;
`endif

  assign tx_ready = ~tx_fifo_full;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_valid & tx_ready),
    .din   (tx_data),
    .pop   (tx_pop),
    .dout  (tx_fifo_dout),
    .full  (tx_fifo_full),
    .empty (tx_fifo_empty),
    .level (tx_level)
  );

  // Fetch the next word when idle, or at the end of STOP for gapless frames
  always_comb begin
    tx_pop = 1'b0;
    if (!tx_fifo_empty) begin
      if (tx_state == ST_IDLE)                          tx_pop = 1'b1;
      else if (tx_state == ST_STOP && tx_cnt == STOP_END) tx_pop = 1'b1;
    end
  end

  // TX frame sequencer: START, DATA (LSB first), optional PARITY, STOP
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state <= ST_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
    end else begin
      case (tx_state)
        ST_IDLE: begin
          if (tx_pop) begin
            tx_shift <= tx_fifo_dout;
            tx_cnt   <= '0;
            tx_state <= ST_START;
          end
        end
        ST_START: begin
          if (tx_cnt == BIT_END) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_state <= ST_DATA;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (tx_cnt == BIT_END) begin
            tx_cnt   <= '0;
            tx_shift <= tx_shift >> 1;
            if (tx_bit == LAST_BIT) begin
`ifdef UART_PARITY_EN
              tx_state <= ST_PARITY;
`else
              tx_state <= ST_STOP;
`endif
            end else begin
              tx_bit <= tx_bit + 1'b1;
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
`ifdef UART_PARITY_EN
        ST_PARITY: begin
          if (tx_cnt == BIT_END) begin
            tx_cnt   <= '0;
            tx_state <= ST_STOP;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
`endif
        ST_STOP: begin
          if (tx_cnt == STOP_END) begin
            tx_cnt <= '0;
            if (tx_pop) begin
              tx_shift <= tx_fifo_dout;
              tx_state <= ST_START;
            end else begin
              tx_state <= ST_IDLE;
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        default: tx_state <= ST_IDLE;
      endcase
    end
  end

`ifdef UART_PARITY_EN
  // Parity is captured at fetch time because the shift register is consumed
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         tx_par <= 1'b0;
    else if (tx_pop) tx_par <= parity_bit(MAX_DATA_BITS'(tx_fifo_dout), DATA_BITS,
                                          PARITY_ODD != 0);
  end
`endif

  // Line level implied by the current TX state
  always_comb begin
    tx_line = 1'b1;
    case (tx_state)
      ST_START:  tx_line = 1'b0;
      ST_DATA:   tx_line = tx_shift[0];
`ifdef UART_PARITY_EN
      ST_PARITY: tx_line = tx_par;
`endif
      default:   tx_line = 1'b1;
    endcase
  end

  // Registered pin drivers; reset forces the line idle-high immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_serial <= 1'b1;
      tx_active <= 1'b0;
    end else begin
      tx_serial <= tx_line;
      tx_active <= (tx_state != ST_IDLE);
    end
  end

  // ---------------------------------------------------------------- RX side
  uart_state_t          rx_state;
  logic [CNT_W-1:0]     rx_cnt;
  logic [BIT_CNT_W-1:0] rx_bit;
  logic [DATA_BITS-1:0] rx_shift;
  logic                 rx_meta;
  logic                 rx_sync;
  logic                 rx_prev;
  logic                 rx_fifo_full;
  logic                 rx_fifo_empty;
  logic                 rx_pop;
  logic                 rx_push;
  logic                 stop_sample;
  logic                 frame_bad;
  logic                 par_bad;
  logic                 overrun_now;
`ifdef UART_PARITY_EN
  logic                 rx_par_bit;
`endif

  assign rx_valid    = ~rx_fifo_empty;
  assign rx_pop      = rx_ready & rx_valid;
  assign stop_sample = (rx_state == ST_STOP) && (rx_cnt == BIT_END);

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push),
    .din   (rx_shift),
    .pop   (rx_pop),
    .dout  (rx_data),
    .full  (rx_fifo_full),
    .empty (rx_fifo_empty),
    .level (rx_level)
  );

  // Two-flop synchroniser plus one delayed copy for falling-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx_serial;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // RX frame sequencer: mid-bit sampling, glitch rejection on START
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state   <= ST_IDLE;
      rx_cnt     <= '0;
      rx_bit     <= '0;
      rx_shift   <= '0;
`ifdef UART_PARITY_EN
      rx_par_bit <= 1'b0;
`endif
    end else begin
      case (rx_state)
        ST_IDLE: begin
          if (rx_prev && !rx_sync) begin
            rx_cnt   <= '0;
            rx_state <= ST_START;
          end
        end
        ST_START: begin
          if (rx_cnt == HALF_END) begin
            rx_cnt <= '0;
            rx_bit <= '0;
            rx_state <= rx_sync ? ST_IDLE : ST_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (rx_cnt == BIT_END) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_sync, rx_shift[DATA_BITS-1:1]};
            if (rx_bit == LAST_BIT) begin
`ifdef UART_PARITY_EN
              rx_state <= ST_PARITY;
`else
              rx_state <= ST_STOP;
`endif
            end else begin
              rx_bit <= rx_bit + 1'b1;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
`ifdef UART_PARITY_EN
        ST_PARITY: begin
          if (rx_cnt == BIT_END) begin
            rx_cnt     <= '0;
            rx_par_bit <= rx_sync;
            rx_state   <= ST_STOP;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
`endif
        ST_STOP: begin
          // Only the first stop bit is sampled; a second one just reads as idle
          if (rx_cnt == BIT_END) begin
            rx_cnt   <= '0;
            rx_state <= ST_IDLE;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        default: rx_state <= ST_IDLE;
      endcase
    end
  end

  // Frame completion verdict at the stop-bit sample, highest priority first
  always_comb begin
    frame_bad   = 1'b0;
    par_bad     = 1'b0;
    overrun_now = 1'b0;
    rx_push     = 1'b0;
    if (stop_sample) begin
      if (!rx_sync) begin
        frame_bad = 1'b1;
`ifdef UART_PARITY_EN
      end else if (rx_par_bit != parity_bit(MAX_DATA_BITS'(rx_shift), DATA_BITS,
                                            PARITY_ODD != 0)) begin
        par_bad = 1'b1;
`endif
      end else if (rx_fifo_full && !rx_pop) begin
        overrun_now = 1'b1;
      end else begin
        rx_push = 1'b1;
      end
    end
  end

  // Error pulses appear in the cycle after the stop-bit sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_frame_err <= 1'b0;
      rx_overrun   <= 1'b0;
    end else begin
      rx_frame_err <= frame_bad;
      rx_overrun   <= overrun_now;
    end
  end

`ifdef UART_PARITY_EN
  // Parity error pulse, aligned with the other error pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rx_parity_err <= 1'b0;
    else     rx_parity_err <= par_bad;
  end
`else
  assign rx_parity_err = par_bad;
`endif

endmodule
